// File: rtl/byte_packer_64.sv
// byte_packer_64: packs a stream of bytes into 64-bit words.
//
// Bytes are assembled little-endian into an assembly buffer: the k-th byte of
// a word lands in bits [8k+7:8k]. A word closes on its eighth byte or on a byte
// flagged in_last, and moves into a single-entry output register. If that
// register is occupied and not draining, the closed word stays in the
// assembly buffer and input is stalled (FULL) until the slot frees up.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    byte to pack
//   in_valid   in_data/in_last valid this cycle
//   in_last    byte ends a packet; closes the current (possibly partial) word
//   in_ready   block accepts a byte this cycle (depends on state only)
//   out_data   packed word, unused upper bytes are zero
//   out_valid  out_data/out_bytes/out_last valid
//   out_bytes  number of valid bytes in out_data, 1..8
//   out_last   word was closed by in_last
//   out_ready  downstream accepts the word this cycle

module byte_packer_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic [3:0]  out_bytes,
    output logic        out_last,
    input  logic        out_ready
);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e      state_q;
    logic [63:0] acc_q;
    logic [2:0]  cnt_q;
    logic        last_q;

    logic        accept;
    logic        closing;
    logic        slot_free;
    logic [63:0] word_next;

    assign in_ready  = (state_q == StFill);
    assign accept    = in_valid && in_ready;
    assign closing   = accept && ((cnt_q == 3'd7) || in_last);
    // The output register can take a new word if it is empty or draining now.
    assign slot_free = !out_valid || out_ready;

    // acc is cleared after every word, so bytes above the new one are already 0.
    always_comb begin
        word_next = acc_q;
        word_next[{cnt_q, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFill;
            acc_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // Drained this edge; a load below overrides for back-to-back words.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        if (closing) begin
                            if (slot_free) begin
                                out_data  <= word_next;
                                out_bytes <= {1'b0, cnt_q} + 4'd1;
                                out_last  <= in_last;
                                out_valid <= 1'b1;
                                acc_q     <= '0;
                                cnt_q     <= '0;
                            end else begin
                                // Hold the closed word; cnt_q keeps its closing index.
                                acc_q   <= word_next;
                                last_q  <= in_last;
                                state_q <= StFull;
                            end
                        end else begin
                            acc_q <= word_next;
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                StFull: begin
                    if (slot_free) begin
                        out_data  <= acc_q;
                        out_bytes <= {1'b0, cnt_q} + 4'd1;
                        out_last  <= last_q;
                        out_valid <= 1'b1;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        last_q    <= 1'b0;
                        state_q   <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_packer_64.sv
// Directed and randomised checks for byte_packer_64.

module tb_byte_packer_64;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic [3:0]  out_bytes;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    byte_packer_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one clock edge, then settle just after the edge.
    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model state for the random stress phase.
    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  nbytes;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [63:0] mdl_acc;
    int          mdl_cnt;
    word_t       w;
    word_t       got;
    int          sent;
    int          cyc;
    int          words_seen;

    initial begin
        rst       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data",  128'(out_data),  128'(0));
        check("reset_out_bytes", 128'(out_bytes), 128'(0));
        check("reset_in_ready",  128'(in_ready),  128'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // Full 8-byte word with out_ready high.
        for (int i = 0; i < 8; i++) begin
            check("full_in_ready", 128'(in_ready), 128'(1));
            send(8'(i + 1), 1'b0);
        end
        check("full_valid", 128'(out_valid), 128'(1));
        check("full_data",  128'(out_data),  128'(64'h0807060504030201));
        check("full_bytes", 128'(out_bytes), 128'(8));
        check("full_last",  128'(out_last),  128'(0));
        idle(1);
        check("full_one_cycle", 128'(out_valid), 128'(0));

        // Partial word closed by in_last; in_valid=0 garbage is ignored.
        send(8'hAA, 1'b0);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("part_valid", 128'(out_valid), 128'(1));
        check("part_data",  128'(out_data),  128'(64'h0000000000CCBBAA));
        check("part_bytes", 128'(out_bytes), 128'(3));
        check("part_last",  128'(out_last),  128'(1));
        idle(1);

        // Single-byte packet.
        send(8'h5A, 1'b1);
        check("single_data",  128'(out_data),  128'(64'h5A));
        check("single_bytes", 128'(out_bytes), 128'(1));
        check("single_last",  128'(out_last),  128'(1));
        idle(1);
        check("single_drained", 128'(out_valid), 128'(0));

        // Backpressure: word A held in output, word B fills and stalls in FULL.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b0);
        check("bp_a_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b0);
        check("bp_full_in_ready", 128'(in_ready), 128'(0));
        check("bp_a_stable",      128'(out_data), 128'(64'h2827262524232221));
        send(8'h99, 1'b1);   // offered while FULL, must not be taken
        check("bp_still_stalled", 128'(in_ready), 128'(0));
        check("bp_a_stable2",     128'(out_data), 128'(64'h2827262524232221));
        check("bp_a_bytes",       128'(out_bytes), 128'(8));
        out_ready = 1'b1;
        send(8'h99, 1'b1);   // release edge: A leaves, B loads, 0x99 not taken
        check("bp_b_valid",    128'(out_valid), 128'(1));
        check("bp_b_data",     128'(out_data),  128'(64'h3837363534333231));
        check("bp_b_bytes",    128'(out_bytes), 128'(8));
        check("bp_in_ready",   128'(in_ready),  128'(1));
        send(8'h99, 1'b1);   // B drains, 0x99 loads back-to-back
        check("bp_next_valid", 128'(out_valid), 128'(1));
        check("bp_next_data",  128'(out_data),  128'(64'h99));
        check("bp_next_bytes", 128'(out_bytes), 128'(1));
        idle(1);
        check("bp_drained", 128'(out_valid), 128'(0));

        // Async reset mid-word with a word sitting in the output register.
        out_ready = 1'b0;
        send(8'h41, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h51 + 8'(i), 1'b0);
        check("rst_pre_valid", 128'(out_valid), 128'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("rst_async_valid", 128'(out_valid), 128'(0));
        check("rst_async_data",  128'(out_data),  128'(0));
        check("rst_async_ready", 128'(in_ready),  128'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        idle(2);
        check("rst_no_ghost", 128'(out_valid), 128'(0));
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0);
        check("rst_word_data",  128'(out_data),  128'(64'h1817161514131211));
        check("rst_word_bytes", 128'(out_bytes), 128'(8));
        check("rst_word_last",  128'(out_last),  128'(0));
        idle(2);

        // Random stress against a byte-level reference model.
        mdl_acc    = '0;
        mdl_cnt    = 0;
        sent       = 0;
        cyc        = 0;
        words_seen = 0;
        while ((sent < 10000 || exp_q.size() != 0) && cyc < 80000) begin
            if (sent < 10000) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = 8'($urandom);
                in_last  = (sent == 9999) ? 1'b1 : ($urandom_range(7) == 0);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                got = '{data: out_data, nbytes: out_bytes, last: out_last};
                if (exp_q.size() == 0) begin
                    check("stress_unexpected_word", 128'(got), 128'(0));
                end else begin
                    w = exp_q.pop_front();
                    check("stress_word", 128'(got), 128'(w));
                    words_seen++;
                end
            end
            if (in_valid && in_ready) begin
                mdl_acc[mdl_cnt*8 +: 8] = in_data;
                if (mdl_cnt == 7 || in_last) begin
                    exp_q.push_back('{data: mdl_acc, nbytes: 4'(mdl_cnt + 1), last: in_last});
                    mdl_acc = '0;
                    mdl_cnt = 0;
                end else begin
                    mdl_cnt++;
                end
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stress_bytes_sent", 128'(sent), 128'(10000));
        check("stress_queue_empty", 128'(exp_q.size()), 128'(0));
        idle(2);
        check("stress_idle_valid", 128'(out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_packer_64.md
BYTE_PACKER_64 -- requirements
Module: byte_packer_64

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset, takes effect without clk).
REQ-003 SHALL have port: in_data  input  8  byte to pack.
REQ-004 SHALL have port: in_valid  input  1  in_data/in_last valid this cycle.
REQ-005 SHALL have port: in_last  input  1  byte is final of a packet; closes current word (partial allowed).
REQ-006 SHALL have port: in_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port: out_data  output  64  packed word, feeds the downstream 64-bit register stage.
REQ-008 SHALL have port: out_valid  output  1  out_data/out_bytes/out_last valid.
REQ-009 SHALL have port: out_bytes  output  4  number of valid bytes in out_data, 1..8.
REQ-010 SHALL have port: out_last  output  1  word closed by in_last.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts word this cycle.

Function
REQ-012 SHALL accept a byte on a rising clk edge iff in_valid=1 and in_ready=1; the output transfer SHALL occur iff out_valid=1 and out_ready=1.
REQ-013 SHALL hold an assembly buffer acc[63:0] and byte counter cnt (0..7); the k-th accepted byte of a word (k=0..7) SHALL be written to acc[8k+7:8k].
REQ-014 SHALL close a word when the accepted byte has cnt=7 or in_last=1; bytes above the closing byte SHALL be 0 in out_data.
REQ-015 SHALL implement states FILL and FULL; in_ready SHALL be 1 in FILL and 0 in FULL, and SHALL depend only on state.
REQ-016 On word close in FILL: if the output slot is free (out_valid=0, or out_valid=1 and out_ready=1 this cycle), the word SHALL load into the output register at the same edge (latency 1 cycle from closing byte to out_valid=1), cnt->0, stay FILL.
REQ-017 On word close in FILL with output slot blocked (out_valid=1, out_ready=0): word SHALL remain in acc with its byte count and last flag, state->FULL.
REQ-018 In FULL: when the slot becomes free, the held word SHALL load into the output register at that edge, acc/cnt cleared, state->FILL; no byte is accepted on that edge.
REQ-019 Output register (out_data, out_bytes, out_last, out_valid) SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 On output transfer with no new word loading, out_valid SHALL go 0 next cycle; with simultaneous load, out_valid SHALL stay 1 carrying the new word (back-to-back, no bubble).
REQ-021 out_bytes SHALL equal closing cnt+1; out_last SHALL equal in_last of the closing byte.
REQ-022 in_valid=1 with in_last=0 when cnt<7 SHALL only append; cnt SHALL never exceed 7 (no wrap beyond a word).
REQ-023 Inputs with in_valid=0 SHALL be ignored regardless of in_data/in_last.
REQ-024 Sustained throughput in FILL with out_ready=1 SHALL be one byte per cycle, one word per 8 cycles.

Reset
REQ-025 rst=0 SHALL immediately (asynchronously) force: state=FILL, cnt=0, acc=0, out_data=0, out_bytes=0, out_last=0, out_valid=0; hence in_ready=1.
REQ-026 Reset mid-word or in FULL SHALL discard the partial/held word and any word in the output register; no word SHALL emerge after reset release.
REQ-027 After rst rises, first accepted byte SHALL be the byte 0 of a new word at the next rising edge with in_valid=1.

Verification
REQ-028 Full word: bytes 0x01..0x08 on 8 consecutive cycles, out_ready=1 -> one cycle later out_data=0x0807060504030201, out_bytes=8, out_last=0, out_valid=1 for one cycle.
REQ-029 Partial: bytes 0xAA,0xBB,0xCC with in_last on 0xCC -> out_data=0x0000000000CCBBAA, out_bytes=3, out_last=1.
REQ-030 Backpressure: out_ready=0 holding word A, then 8 more bytes -> state FULL, in_ready=0 the cycle after 8th byte; A stable; out_ready=1 -> A transfers, B loaded same edge, in_ready=1 next cycle.
REQ-031 Single-byte packet: 0x5A with in_last, cnt=0 -> out_data=0x5A, out_bytes=1, out_last=1.
REQ-032 Async reset: assert rst=0 between clock edges with cnt=5 and out_valid=1 -> out_valid=0, out_data=0 immediately; after release, bytes 0x11..0x18 yield 0x1817161514131211.
REQ-033 Random in_valid/out_ready stress, 10^4 bytes with random in_last -> scoreboard match of every byte, order, out_bytes, out_last; no loss, no duplication.
